multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Moore FSM controller for the multi-cycle RV32I datapath: one shared memory, one ALU, IR/OldPC/ALUOut/Data registers.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives every enable and mux select of the datapath.
- Decodes the same op/func3/func7 fields and instruction subset as the single-cycle controller, and emits the same ALUControl/ImmSrc encodings.

Parameters:
- MEM_WAIT_EN, 1, when 1, FETCH/MEMREAD/MEMWRITE hold until mem_ready=1; when 0, mem_ready is ignored (treated as 1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  7  IR[6:0]
- func3  in  3  IR[14:12]
- func7  in  7  IR[31:25]
- branch_cond  in  1  datapath comparator result for current func3 (valid in BRANCH)
- mem_ready  in  1  memory access complete this cycle
- PCWrite  out  1  load PC
- AdrSrc  out  1  0=PC, 1=ALUOut as memory address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load IR and OldPC
- ResultSrc  out  2  0=ALUOut, 1=Data, 2=ALUResult, 3=ImmExt
- ALUSrcA  out  2  0=PC, 1=OldPC, 2=rs1
- ALUSrcB  out  2  0=rs2, 1=ImmExt, 2=constant 4
- ALUControl  out  3  ALU operation
- ImmSrc  out  3  immediate format
- RegWrite  out  1  register-file write
- illegal  out  1  one-cycle pulse when an unsupported instruction is dropped
- state_dbg  out  4  current state encoding

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR_ADR, JALR_PC, LUI.
- Reset: rst=1 at a clock edge forces state=FETCH. While rst=1, all outputs are 0, including PCWrite, IRWrite, MemWrite, RegWrite and illegal.
- Reset mid-instruction abandons it; no partial write occurs after the reset edge.
- Outputs are a pure function of state and decoded fields. Unlisted outputs are 0.
- FETCH: AdrSrc=0, IRWrite, ALUSrcA=0, ALUSrcB=2, add, ResultSrc=2, PCWrite.
  - IRWrite and PCWrite are gated by mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=1, add, ImmSrc=B (precomputes the branch/jal target into ALUOut). Next state by op:
  - load or store -> MEMADR
  - R-type -> EXEC_R
  - I-type ALU -> EXEC_I
  - B-type -> BRANCH
  - jal -> JAL
  - jalr -> JALR_ADR
  - lui -> LUI
  - anything else -> FETCH with illegal=1
- MEMADR: rs1+imm, with ImmSrc=S for stores and I for loads. Loads go to MEMREAD, stores to MEMWRITE.
- MEMREAD: AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=1, RegWrite, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite held until mem_ready, then FETCH.
- EXEC_R: ALUSrcA=2, ALUSrcB=0, then ALUWB. ALUControl from func7/func3:
  - add, sub (func7=0100000 with func3=000), slt, sltu, xor, or, and.
  - sll, srl, sra or any other func7 -> illegal=1 and go to FETCH instead; no RegWrite.
- EXEC_I: rs1+imm with ImmSrc=I, then ALUWB.
  - ALUControl from func3: addi, slti, sltiu, xori, ori, andi.
  - Shift-immediates -> illegal and FETCH.
- ALUWB: ResultSrc=0, RegWrite, then FETCH.
- BRANCH: ALUSrcA=2, ALUSrcB=0, sub, ResultSrc=0. PCWrite=branch_cond, then FETCH.
- JAL: ResultSrc=0, PCWrite (target from DECODE); ALUSrcA=1, ALUSrcB=2, add (OldPC+4), then ALUWB.
- JALR_ADR: ALUSrcA=2, ALUSrcB=1, ImmSrc=I, add, then JALR_PC.
- JALR_PC: identical to JAL, then ALUWB.
- LUI: ResultSrc=3, ImmSrc=U, RegWrite, then FETCH.
- Latency with mem_ready=1:
  - 3 cycles: branch, lui
  - 4 cycles: R-type, I-type ALU, store, jal
  - 5 cycles: load, jalr
- Each cycle of mem_ready=0 in a memory state adds one cycle. The state is held with all outputs held constant, except that gated enables stay 0.
- Illegal handling: illegal pulses for exactly one cycle, from DECODE or EXEC_R/EXEC_I. PC has already advanced to PC+4.

Decomposition:
- Shared package (extends the existing constants include): opcode values, func3/func7 values, ALUControl codes (add 000, sub 001, and 010, or 011, xor 100, slt 101, sltu 110), ImmSrc codes (I 000, S 001, B 010, J 011, U 100), ResultSrc/ALUSrcA/ALUSrcB codes, and the state enumeration.
- One sub-module, alu_decoder: a combinational op/func3/func7 -> ALUControl + valid mapping, reused by EXEC_R and EXEC_I.

Test Plan:
- rst=1 for 2 cycles mid-JALR_ADR -> state_dbg=FETCH, all write enables 0; after rst release, a fetch occurs with PCWrite=1 in cycle 1.
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALUWB; ALUControl=000; RegWrite only in ALUWB; 4 cycles total.
- lw x5,8(x1) (0x0080A283) with mem_ready low for 3 cycles in MEMREAD -> MEMREAD lasts 4 cycles, RegWrite=1 with ResultSrc=1 once; 8 cycles total.
- beq with branch_cond=0, then branch_cond=1 -> PCWrite in BRANCH is 0, then 1; RegWrite never asserted; 3 cycles each.
- jal x1,+16 (0x010000EF) -> PCWrite in FETCH and in JAL; RegWrite in ALUWB with ALUSrcA=1, ALUSrcB=2; 4 cycles.
- sll (func3=001, func7=0) and opcode 0x7F -> illegal=1 pulse, return to FETCH, no RegWrite or MemWrite.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multi-cycle RV32I controller: opcodes, function
// fields, ALU/immediate/mux encodings, control bundle and state enumeration.
package multicycle_controller_pkg;

  // Opcodes of the supported instruction subset
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  // func3 values for the arithmetic group
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // func7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  // ImmSrc codes
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // ResultSrc codes
  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;
  localparam logic [1:0] RES_IMMEXT    = 2'd3;

  // ALUSrcA codes
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  // ALUSrcB codes
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // Controller states; the encoding is visible on state_dbg
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR_ADR = 4'd11,
    JALR_PC  = 4'd12,
    LUI      = 4'd13
  } state_t;

  // Every datapath control in one bundle so it can be cleared in one go
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [2:0] imm_src;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  // True for every opcode the controller knows how to sequence
  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BTYPE) || (op == OP_JAL) ||
           (op == OP_JALR) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational op/func3/func7 to ALUControl mapping shared by the R-type
// and I-type execute states. valid=0 marks shifts and unknown encodings.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] alu_control,
  output logic       valid
);

  logic [2:0] base_code;
  logic       base_ok;

  // func3 decode common to register and immediate forms; shifts are unsupported
  always_comb begin
    base_code = ALU_ADD;
    base_ok   = 1'b1;
    case (func3)
      F3_ADD:  base_code = ALU_ADD;
      F3_SLT:  base_code = ALU_SLT;
      F3_SLTU: base_code = ALU_SLTU;
      F3_XOR:  base_code = ALU_XOR;
      F3_OR:   base_code = ALU_OR;
      F3_AND:  base_code = ALU_AND;
      default: base_ok   = 1'b0;
    endcase
  end

  // R-type also needs func7 (sub is the only alternate encoding kept); an
  // invalid result still reports add so the ALU sees a harmless operation
  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b0;
    if (op == OP_RTYPE) begin
      if ((func7 == F7_ALT) && (func3 == F3_ADD)) begin
        alu_control = ALU_SUB;
        valid       = 1'b1;
      end else if ((func7 == F7_BASE) && base_ok) begin
        alu_control = base_code;
        valid       = 1'b1;
      end
    end else if ((op == OP_ITYPE) && base_ok) begin
      alu_control = base_code;
      valid       = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multi-cycle RV32I datapath through fetch, decode,
// execute, memory and writeback, driving every enable and mux select.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t     state;
  state_t     state_next;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;
  logic       ready;
  logic [2:0] dec_alu_control;
  logic       dec_valid;

  // With waiting disabled every memory access completes in one cycle
  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  multicycle_controller_alu_decoder u_alu_decoder (
    .op          (op),
    .func3       (func3),
    .func7       (func7),
    .alu_control (dec_alu_control),
    .valid       (dec_valid)
  );

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      FETCH:    if (ready) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXEC_R;
          OP_ITYPE:          state_next = EXEC_I;
          OP_BTYPE:          state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR_ADR;
          OP_LUI:            state_next = LUI;
          default:           state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (ready) state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: if (ready) state_next = FETCH;
      EXEC_R,
      EXEC_I:   state_next = dec_valid ? ALUWB : FETCH;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      JAL:      state_next = ALUWB;
      JALR_ADR: state_next = JALR_PC;
      JALR_PC:  state_next = ALUWB;
      LUI:      state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  // Control outputs per state; only fetch enables and the branch PC load
  // look at live inputs, everything else is fixed by state and IR fields
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.adr_src     = 1'b0;
        ctrl.ir_write    = ready;
        ctrl.pc_write    = ready;
        ctrl.alu_src_a   = SRCA_PC;
        ctrl.alu_src_b   = SRCB_FOUR;
        ctrl.alu_control = ALU_ADD;
        ctrl.result_src  = RES_ALURESULT;
      end
      DECODE: begin
        ctrl.alu_src_a   = SRCA_OLDPC;
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.alu_control = ALU_ADD;
        ctrl.imm_src     = IMM_B;
        ctrl.illegal     = ~op_supported(op);
      end
      MEMADR: begin
        ctrl.alu_src_a   = SRCA_RS1;
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.alu_control = ALU_ADD;
        ctrl.imm_src     = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      MEMREAD: begin
        ctrl.adr_src = 1'b1;
      end
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      EXEC_R: begin
        ctrl.alu_src_a   = SRCA_RS1;
        ctrl.alu_src_b   = SRCB_RS2;
        ctrl.alu_control = dec_alu_control;
        ctrl.illegal     = ~dec_valid;
      end
      EXEC_I: begin
        ctrl.alu_src_a   = SRCA_RS1;
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.imm_src     = IMM_I;
        ctrl.alu_control = dec_alu_control;
        ctrl.illegal     = ~dec_valid;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a   = SRCA_RS1;
        ctrl.alu_src_b   = SRCB_RS2;
        ctrl.alu_control = ALU_SUB;
        ctrl.result_src  = RES_ALUOUT;
        ctrl.pc_write    = branch_cond;
      end
      JAL, JALR_PC: begin
        ctrl.result_src  = RES_ALUOUT;
        ctrl.pc_write    = 1'b1;
        ctrl.alu_src_a   = SRCA_OLDPC;
        ctrl.alu_src_b   = SRCB_FOUR;
        ctrl.alu_control = ALU_ADD;
      end
      JALR_ADR: begin
        ctrl.alu_src_a   = SRCA_RS1;
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.imm_src     = IMM_I;
        ctrl.alu_control = ALU_ADD;
      end
      LUI: begin
        ctrl.result_src = RES_IMMEXT;
        ctrl.imm_src    = IMM_U;
        ctrl.reg_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Reset silences every output so nothing is written during the reset cycle
  assign ctrl_out   = rst ? '0 : ctrl;
  assign PCWrite    = ctrl_out.pc_write;
  assign AdrSrc     = ctrl_out.adr_src;
  assign MemWrite   = ctrl_out.mem_write;
  assign IRWrite    = ctrl_out.ir_write;
  assign ResultSrc  = ctrl_out.result_src;
  assign ALUSrcA    = ctrl_out.alu_src_a;
  assign ALUSrcB    = ctrl_out.alu_src_b;
  assign ALUControl = ctrl_out.alu_control;
  assign ImmSrc     = ctrl_out.imm_src;
  assign RegWrite   = ctrl_out.reg_write;
  assign illegal    = ctrl_out.illegal;
  assign state_dbg  = rst ? 4'd0 : 4'(state);

endmodule
